// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
//
// Posted-write buffer that sits between the MEM-stage store path and the data
// memory write port. Stores (word/half/byte) are queued in a small FIFO and
// drained to DM at most one per cycle, whenever a load is not using the DM port.
// A load that targets a word with a pending store raises ld_hazard, so hazard
// control can stall until that store has drained.
//
// Parameters
//   DEPTH     number of FIFO entries (power of two, >= 2)
//   AW        pointer width, equal to log2(DEPTH)
//
// Ports
//   clk        in   1   clock, all state updates on posedge
//   reset      in   1   synchronous, active-high; discards all pending stores
//   st_valid   in   1   MEM stage presents a store this cycle
//   st_ready   out  1   buffer can accept a store (not full)
//   st_addr    in   32  store byte address
//   st_data    in   32  store data (DM does lane placement for H/B)
//   st_sel     in   3   access size code, stored as-is
//   st_pc      in   32  PC of the store, carried for the write trace
//   ld_valid   in   1   MEM stage presents a load this cycle
//   ld_addr    in   32  load byte address
//   ld_hazard  out  1   load word matches a pending store; stall required
//   dm_busy    in   1   DM port claimed by a load this cycle; drain blocked
//   dm_we      out  1   DM write strobe (head entry commits on this posedge)
//   dm_addr    out  32  head entry address (0 when empty)
//   dm_wdata   out  32  head entry data    (0 when empty)
//   dm_sel     out  3   head entry size    (0 when empty)
//   dm_pc      out  32  head entry PC      (0 when empty)
//   empty      out  1   no pending stores
// -----------------------------------------------------------------------------
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_sel,
    input  logic [31:0] st_pc,

    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,

    input  logic        dm_busy,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_sel,
    output logic [31:0] dm_pc,

    output logic        empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [DEPTH-1:0] valid_q,  valid_d;

    logic [31:0] addr_q [DEPTH];
    logic [31:0] addr_d [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];
    logic [2:0]  sel_q  [DEPTH];
    logic [2:0]  sel_d  [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] pc_d   [DEPTH];

    logic push;
    logic pop;
    logic has_entry;
    logic word_hit;

    // The word compare ignores the byte offset within the word.
    logic unused_ld_addr_lsbs;
    assign unused_ld_addr_lsbs = ^ld_addr[1:0];

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // st_ready looks only at registered count: when full, a pop in the same
    // cycle does not open a slot, and the store retries next cycle. This keeps
    // st_ready free of any path from dm_busy.
    assign has_entry = (count_q != '0);
    assign st_ready  = (count_q != FULL_COUNT);
    assign empty     = ~has_entry;

    assign push = st_valid & st_ready;
    assign pop  = has_entry & ~dm_busy;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        sel_d    = sel_q;
        pc_d     = pc_q;

        // push and pop can only address the same slot when count is 0 or
        // DEPTH, and in either case one of them is disabled, so the clear and
        // the set below never collide.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
        end

        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = st_addr;
            data_d[wr_ptr_q]  = st_data;
            sel_d[wr_ptr_q]   = st_sel;
            pc_d[wr_ptr_q]    = st_pc;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // NOTE: the payload array is deliberately not reset; the valid bits and
    // count gate every use of it, so clearing it would only cost reset fanout.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        sel_q  <= sel_d;
        pc_q   <= pc_d;
    end

    // -------------------------------------------------------------------------
    // Drain port
    // -------------------------------------------------------------------------
    // Head fields are forced to zero when empty so the DM trace never shows
    // stale payload; the store inputs are never bypassed to DM.
    assign dm_we    = pop;
    assign dm_addr  = has_entry ? addr_q[rd_ptr_q] : 32'h0;
    assign dm_wdata = has_entry ? data_q[rd_ptr_q] : 32'h0;
    assign dm_sel   = has_entry ? sel_q[rd_ptr_q]  : 3'h0;
    assign dm_pc    = has_entry ? pc_q[rd_ptr_q]   : 32'h0;

    // -------------------------------------------------------------------------
    // Load hazard
    // -------------------------------------------------------------------------
    // Compares against stored entries only, including the head being drained
    // this cycle (conservative: the load stalls one extra cycle instead of
    // racing the DM write). A store arriving on st_* this cycle is not seen.
    always_comb begin
        word_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid & word_hit;

endmodule

// File: tb/tb_dm_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_store_buffer
//
// Directed self-checking bench for dm_store_buffer. Inputs change 1 ns after a
// rising edge; outputs are compared 1 ns later, mid-cycle. A monitor on the
// falling edge logs every DM write (the write commits on the next rising edge)
// so ordering can be compared against the stream of accepted stores.
// -----------------------------------------------------------------------------
module tb_dm_store_buffer;

    localparam logic [2:0] DM_W = 3'b000;
    localparam logic [2:0] DM_H = 3'b001;
    localparam logic [2:0] DM_B = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
        logic [31:0] pc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_sel;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        dm_busy;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_sel;
    logic [31:0] dm_pc;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    wr_t wr_log [$];
    wr_t exp_q  [$];

    dm_store_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_sel   (st_sel),
        .st_pc    (st_pc),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hazard(ld_hazard),
        .dm_busy  (dm_busy),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_sel   (dm_sel),
        .dm_pc    (dm_pc),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dm_we) begin
            wr_log.push_back('{addr: dm_addr, data: dm_wdata, sel: dm_sel, pc: dm_pc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] s, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_sel   = s;
        st_pc    = p;
    endtask

    logic [31:0] t2_addr [5];
    logic [31:0] t2_data [5];
    int          idx;
    bit          accepted;

    initial begin
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_sel   = '0;
        st_pc    = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        dm_busy  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        #1;
        check("rst_st_ready",  32'(st_ready),  32'd1);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_ld_hazard", 32'(ld_hazard), 32'd0);
        check("rst_dm_we",     32'(dm_we),     32'd0);
        check("rst_dm_addr",   dm_addr,        32'h0);
        check("rst_dm_wdata",  dm_wdata,       32'h0);
        check("rst_dm_sel",    32'(dm_sel),    32'h0);
        check("rst_dm_pc",     dm_pc,          32'h0);
        reset = 1'b0;
        tick();

        // ---- 1: single store, one-cycle latency ----
        drive_st(32'h0000_0010, 32'h1234_5678, DM_W, 32'h0000_3000);
        #1;
        check("t1_no_bypass_we", 32'(dm_we), 32'd0);
        check("t1_no_bypass_addr", dm_addr, 32'h0);
        tick();
        st_valid = 1'b0;
        #1;
        check("t1_dm_we",    32'(dm_we),  32'd1);
        check("t1_dm_addr",  dm_addr,     32'h0000_0010);
        check("t1_dm_wdata", dm_wdata,    32'h1234_5678);
        check("t1_dm_pc",    dm_pc,       32'h0000_3000);
        check("t1_dm_sel",   32'(dm_sel), 32'(DM_W));
        check("t1_not_empty", 32'(empty), 32'd0);
        tick();
        #1;
        check("t1_empty_after", 32'(empty), 32'd1);
        check("t1_we_after",    32'(dm_we), 32'd0);

        // ---- 2 + 4: fill while DM busy, full-cycle pop blocks push ----
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h100 + 32'(4*i), 32'hA0 + 32'(i), DM_H, 32'h4000 + 32'(4*i));
            #1;
            check($sformatf("t2_ready_%0d", i), 32'(st_ready), 32'd1);
            tick();
        end
        drive_st(32'h0000_0200, 32'h0000_0055, DM_W, 32'h0000_4010);
        #1;
        check("t2_full_ready", 32'(st_ready), 32'd0);
        check("t2_busy_no_we", 32'(dm_we),    32'd0);
        tick();
        #1;
        check("t2_held_ready", 32'(st_ready), 32'd0);
        check("t2_held_head",  dm_addr,       32'h0000_0100);

        t2_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h200};
        t2_data = '{32'hA0,  32'hA1,  32'hA2,  32'hA3,  32'h55};
        dm_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t2_we_%0d", i),    32'(dm_we), 32'd1);
            check($sformatf("t2_addr_%0d", i),  dm_addr,    t2_addr[i]);
            check($sformatf("t2_data_%0d", i),  dm_wdata,   t2_data[i]);
            if (i == 0) check("t4_full_pop_no_push", 32'(st_ready), 32'd0);
            if (i == 1) check("t4_push_next_cycle",  32'(st_ready), 32'd1);
            tick();
            if (i == 1) st_valid = 1'b0;
        end
        #1;
        check("t2_drained_empty", 32'(empty), 32'd1);
        check("t2_drained_we",    32'(dm_we), 32'd0);

        // ---- 3: load hazard ----
        dm_busy = 1'b1;
        drive_st(32'h0000_0023, 32'h0000_00EF, DM_B, 32'h0000_5000);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0020;
        #1;
        check("t3_hit_same_word", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h0000_0024;
        #1;
        check("t3_next_word", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h0000_0023;
        #1;
        check("t3_hit_exact", 32'(ld_hazard), 32'd1);
        ld_valid = 1'b0;
        ld_addr  = 32'h0000_0020;
        #1;
        check("t3_no_ld_valid", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b1;
        dm_busy  = 1'b0;
        #1;
        check("t3_hit_while_draining", 32'(ld_hazard), 32'd1);
        check("t3_drain_sel", 32'(dm_sel), 32'(DM_B));
        tick();
        #1;
        check("t3_after_drain", 32'(ld_hazard), 32'd0);
        // A store arriving in the same cycle is not compared.
        dm_busy = 1'b1;
        ld_addr = 32'h0000_0040;
        drive_st(32'h0000_0040, 32'h0000_0001, DM_W, 32'h0000_5004);
        #1;
        check("t3_same_cycle_store", 32'(ld_hazard), 32'd0);
        tick();
        st_valid = 1'b0;
        #1;
        check("t3_stored_next_cycle", 32'(ld_hazard), 32'd1);
        ld_valid = 1'b0;
        dm_busy  = 1'b0;
        tick();
        #1;
        check("t3_final_empty", 32'(empty), 32'd1);

        // ---- 5: reset with pending entries ----
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h300 + 32'(4*i), 32'hB0 + 32'(i), DM_W, 32'h7000 + 32'(4*i));
            tick();
        end
        st_valid = 1'b0;
        #1;
        check("t5_pending", 32'(empty), 32'd0);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        dm_busy = 1'b0;
        #1;
        check("t5_empty",     32'(empty),    32'd1);
        check("t5_dm_we",     32'(dm_we),    32'd0);
        check("t5_st_ready",  32'(st_ready), 32'd1);
        wr_log.delete();
        for (int i = 0; i < 4; i++) tick();
        check("t5_no_writes", 32'(wr_log.size()), 32'd0);

        // ---- 6: mixed push/pop stream across pointer wrap ----
        wr_log.delete();
        exp_q.delete();
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 20; cyc++) begin
            drive_st(32'h1000 + 32'(4*idx), 32'hC0DE_0000 + 32'(idx),
                     (idx == 7) ? 3'b111 : 3'(idx % 3), 32'h6000 + 32'(4*idx));
            dm_busy = (cyc % 3 == 0);
            #1;
            accepted = st_ready;
            tick();
            if (accepted) begin
                exp_q.push_back('{addr: 32'h1000 + 32'(4*idx), data: 32'hC0DE_0000 + 32'(idx),
                                  sel: (idx == 7) ? 3'b111 : 3'(idx % 3),
                                  pc: 32'h6000 + 32'(4*idx)});
                idx++;
            end
        end
        st_valid = 1'b0;
        dm_busy  = 1'b0;
        check("t6_all_accepted", 32'(idx), 32'd20);
        for (int w = 0; w < 10 && !empty; w++) tick();
        #1;
        check("t6_drain_empty", 32'(empty), 32'd1);
        check("t6_write_count", 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            check($sformatf("t6_addr_%0d", i), wr_log[i].addr, exp_q[i].addr);
            check($sformatf("t6_data_%0d", i), wr_log[i].data, exp_q[i].data);
            check($sformatf("t6_sel_%0d", i),  32'(wr_log[i].sel), 32'(exp_q[i].sel));
            check($sformatf("t6_pc_%0d", i),   wr_log[i].pc,   exp_q[i].pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
